// File: rtl/btn_intr_ctrl.sv
// rtl/btn_intr_ctrl.sv - button event interrupt controller: pending capture, mask, arbitration, ack holdoff
// Define BTN_INTR_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module btn_intr_ctrl #(
  parameter int N_SRC        = 4,
  parameter int ID_W         = 2,
  parameter int HOLDOFF_CLKS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] SRC_PULSE,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_IN,
  input  logic             OVR_CLR,
  input  logic             INTR_ACK,
  output logic             INTR,
  output logic [ID_W-1:0]  INTR_ID,
  output logic [N_SRC-1:0] MASK,
  output logic [N_SRC-1:0] PENDING,
  output logic [N_SRC-1:0] OVERRUN
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [7:0]  HOLD_LAST = 8'(HOLDOFF_CLKS - 1);
  localparam logic [ID_W:0] N_W     = (ID_W+1)'(N_SRC);

  state_t           state, state_nx;
  logic [7:0]       hold_cnt, hold_cnt_nx;
  logic [N_SRC-1:0] req, captured, ack_clr, ovr_evt;
  logic [ID_W-1:0]  grant, id_nx, scan_idx;
  logic [ID_W:0]    scan_sum;
  logic             ack_fire, grant_vld;

`ifndef BTN_INTR_FIXED_PRIO_EN
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nx;
  logic [ID_W:0]    ptr_inc;
`endif

  assign req      = PENDING & MASK;
  assign captured = SRC_PULSE & MASK;
  assign ack_fire = (state == ASSERT) && INTR_ACK;
  assign ack_clr  = ack_fire ? (N_SRC'(1) << INTR_ID) : '0;
  // A capture in the ack-clear cycle of the same source is a fresh event, not a lost one
  assign ovr_evt  = captured & PENDING & ~ack_clr;
  assign INTR     = (state == ASSERT);

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_SRC; k++) begin
`ifdef BTN_INTR_FIXED_PRIO_EN
      scan_idx = ID_W'(k);
`else
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= N_W) scan_sum = scan_sum - N_W;
      scan_idx = scan_sum[ID_W-1:0];
`endif
      if (!grant_vld && req[scan_idx]) begin
        grant     = scan_idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    id_nx       = INTR_ID;
`ifndef BTN_INTR_FIXED_PRIO_EN
    rr_ptr_nx   = rr_ptr;
    ptr_inc     = {1'b0, INTR_ID} + (ID_W+1)'(1);
    if (ptr_inc == N_W) ptr_inc = '0;
`endif
    case (state)
      IDLE: begin
        if (grant_vld) begin
          id_nx    = grant;
          state_nx = ASSERT;
        end
      end
      ASSERT: begin
        if (INTR_ACK) begin
          state_nx    = HOLDOFF;
          hold_cnt_nx = '0;
`ifndef BTN_INTR_FIXED_PRIO_EN
          rr_ptr_nx   = ptr_inc[ID_W-1:0];
`endif
        end
      end
      HOLDOFF: begin
        hold_cnt_nx = hold_cnt + 8'd1;
        if (hold_cnt == HOLD_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hold_cnt <= '0;
      INTR_ID  <= '0;
      MASK     <= '0;
      PENDING  <= '0;
      OVERRUN  <= '0;
`ifndef BTN_INTR_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
      INTR_ID  <= id_nx;
      if (MASK_WE) MASK <= MASK_IN;
      PENDING  <= (PENDING & ~ack_clr) | captured;
      OVERRUN  <= (OVR_CLR ? '0 : OVERRUN) | ovr_evt;
`ifndef BTN_INTR_FIXED_PRIO_EN
      rr_ptr   <= rr_ptr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_btn_intr_ctrl.sv
// tb/tb_btn_intr_ctrl.sv - self-checking bench for btn_intr_ctrl with a behavioural reference model
module tb_btn_intr_ctrl;
  localparam int N = 4;
  localparam int H = 8;

  logic       CLK = 1'b0;
  logic       RST, MASK_WE, OVR_CLR, INTR_ACK;
  logic [3:0] SRC_PULSE, MASK_IN;
  logic       INTR;
  logic [1:0] INTR_ID;
  logic [3:0] MASK, PENDING, OVERRUN;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_mask, m_pend, m_ovr;
  bit         m_intr;
  int         m_id, m_hold, m_ptr;

  always #5 CLK = ~CLK;

  btn_intr_ctrl #(.N_SRC(N), .ID_W(2), .HOLDOFF_CLKS(H)) dut (
    .CLK(CLK), .RST(RST), .SRC_PULSE(SRC_PULSE), .MASK_WE(MASK_WE), .MASK_IN(MASK_IN),
    .OVR_CLR(OVR_CLR), .INTR_ACK(INTR_ACK), .INTR(INTR), .INTR_ID(INTR_ID),
    .MASK(MASK), .PENDING(PENDING), .OVERRUN(OVERRUN)
  );

  function automatic int pick(logic [3:0] req, int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic clear_inputs();
    RST = 0; MASK_WE = 0; OVR_CLR = 0; INTR_ACK = 0; SRC_PULSE = '0; MASK_IN = '0;
  endtask

  // Advance one clock: the model consumes the inputs presented for this cycle
  task automatic tick();
    logic [3:0] ev, lost;
    bit ack;
    int g, ptr;
    if (RST) begin
      m_mask = '0; m_pend = '0; m_ovr = '0; m_intr = 0; m_id = 0; m_hold = 0; m_ptr = 0;
    end else begin
      ack = m_intr && INTR_ACK;
      ev = '0; lost = '0;
      for (int i = 0; i < N; i++) begin
        if (SRC_PULSE[i] && m_mask[i]) begin
          ev[i] = 1'b1;
          if (m_pend[i] && !(ack && i == m_id)) lost[i] = 1'b1;
        end
      end
`ifdef BTN_INTR_FIXED_PRIO_EN
      ptr = 0;
`else
      ptr = m_ptr;
`endif
      g = pick(m_pend & m_mask, ptr);
      if (ack) m_pend[m_id] = 1'b0;
      m_pend = m_pend | ev;
      if (OVR_CLR) m_ovr = '0;
      m_ovr = m_ovr | lost;
      if (m_intr) begin
        if (ack) begin m_intr = 0; m_hold = H; m_ptr = (m_id + 1) % N; end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (g >= 0) begin
        m_id = g; m_intr = 1;
      end
      if (MASK_WE) m_mask = MASK_IN;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs(); RST = 1; tick(); RST = 0;
  endtask

  task automatic write_mask(input logic [3:0] m);
    MASK_WE = 1; MASK_IN = m; tick(); MASK_WE = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (INTR !== 1'b0) begin n_err++; $display("FAIL reset_intr: got %0b want 0", INTR); end
    n_cmp++; if (INTR_ID !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", INTR_ID); end
    n_cmp++; if (MASK !== 4'b0) begin n_err++; $display("FAIL reset_mask: got %b want 0000", MASK); end
    n_cmp++; if (PENDING !== 4'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0000", PENDING); end
    n_cmp++; if (OVERRUN !== 4'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0000", OVERRUN); end
  endtask

  task automatic test_latency_hold();
    write_mask(4'b1111);
    n_cmp++; if (MASK !== 4'b1111) begin n_err++; $display("FAIL mask_write: got %b want 1111", MASK); end
    SRC_PULSE = 4'b0100; tick(); SRC_PULSE = '0;
    n_cmp++; if (PENDING !== 4'b0100) begin n_err++; $display("FAIL lat_pending: got %b want 0100", PENDING); end
    n_cmp++; if (INTR !== 1'b0) begin n_err++; $display("FAIL lat_intr_early: got %0b want 0", INTR); end
    tick();
    n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'd2) begin
      n_err++; $display("FAIL lat_intr: got intr=%0b id=%0d want intr=1 id=2", INTR, INTR_ID); end
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'd2) begin
        n_err++; $display("FAIL hold_no_ack c=%0d: got intr=%0b id=%0d want intr=1 id=2", c, INTR, INTR_ID); end
    end
  endtask

  task automatic test_ack_holdoff();
    INTR_ACK = 1; tick(); INTR_ACK = 0;
    n_cmp++; if (PENDING !== 4'b0 || INTR !== 1'b0) begin
      n_err++; $display("FAIL ack_clear: got pend=%b intr=%0b want pend=0000 intr=0", PENDING, INTR); end
    for (int c = 0; c < H + 4; c++) begin
      tick();
      n_cmp++; if (INTR !== 1'b0) begin n_err++; $display("FAIL ack_stays_low c=%0d: got %0b want 0", c, INTR); end
    end
    SRC_PULSE = 4'b0010; tick(); SRC_PULSE = '0; tick();
    n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'd1) begin
      n_err++; $display("FAIL second_grant: got intr=%0b id=%0d want intr=1 id=1", INTR, INTR_ID); end
    INTR_ACK = 1; SRC_PULSE = 4'b1000; tick(); INTR_ACK = 0; SRC_PULSE = '0;
    for (int k = 1; k <= H + 1; k++) begin
      tick();
      if (k <= H) begin
        n_cmp++; if (INTR !== 1'b0) begin n_err++; $display("FAIL holdoff_gap k=%0d: got %0b want 0", k, INTR); end
      end else begin
        n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'd3) begin
          n_err++; $display("FAIL reassert k=%0d: got intr=%0b id=%0d want intr=1 id=3", k, INTR, INTR_ID); end
      end
    end
    INTR_ACK = 1; tick(); INTR_ACK = 0;
    for (int c = 0; c < H + 2; c++) tick();
  endtask

  task automatic test_rr_order();
    int exp1[3] = '{0, 1, 3};
`ifdef BTN_INTR_FIXED_PRIO_EN
    int exp2[3] = '{0, 0, 0};
    logic [3:0] exp_ovr = 4'b0000;
`else
    int exp2[3] = '{0, 1, 0};
    logic [3:0] exp_ovr = 4'b0001;
`endif
    int w;
    do_reset(); write_mask(4'b1111);
    SRC_PULSE = 4'b1011; tick(); SRC_PULSE = '0;
    for (int r = 0; r < 3; r++) begin
      w = 0;
      while (INTR !== 1'b1 && w < 20) begin tick(); w++; end
      n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'(exp1[r])) begin
        n_err++; $display("FAIL rr_order r=%0d: got intr=%0b id=%0d want intr=1 id=%0d", r, INTR, INTR_ID, exp1[r]); end
      INTR_ACK = 1; tick(); INTR_ACK = 0;
    end
    for (int c = 0; c < 15; c++) tick();
    n_cmp++; if (INTR !== 1'b0 || PENDING !== 4'b0) begin
      n_err++; $display("FAIL rr_idle: got intr=%0b pend=%b want intr=0 pend=0000", INTR, PENDING); end
    do_reset(); write_mask(4'b1111);
    SRC_PULSE = 4'b0011; tick(); SRC_PULSE = '0;
    for (int r = 0; r < 3; r++) begin
      w = 0;
      while (INTR !== 1'b1 && w < 20) begin tick(); w++; end
      n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'(exp2[r])) begin
        n_err++; $display("FAIL repulse_order r=%0d: got intr=%0b id=%0d want intr=1 id=%0d", r, INTR, INTR_ID, exp2[r]); end
      INTR_ACK = 1; SRC_PULSE = 4'b0001; tick(); INTR_ACK = 0; SRC_PULSE = '0;
    end
    n_cmp++; if (OVERRUN !== exp_ovr) begin
      n_err++; $display("FAIL repulse_overrun: got %b want %b", OVERRUN, exp_ovr); end
  endtask

  task automatic test_overrun();
    do_reset(); write_mask(4'b1111);
    SRC_PULSE = 4'b0010; tick(); SRC_PULSE = '0; tick();
    SRC_PULSE = 4'b0010; tick(); SRC_PULSE = '0;
    n_cmp++; if (OVERRUN !== 4'b0010 || PENDING !== 4'b0010) begin
      n_err++; $display("FAIL ovr_set: got ovr=%b pend=%b want ovr=0010 pend=0010", OVERRUN, PENDING); end
    OVR_CLR = 1; tick(); OVR_CLR = 0;
    n_cmp++; if (OVERRUN !== 4'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0000", OVERRUN); end
    OVR_CLR = 1; SRC_PULSE = 4'b0010; tick(); OVR_CLR = 0; SRC_PULSE = '0;
    n_cmp++; if (OVERRUN !== 4'b0010) begin n_err++; $display("FAIL ovr_clr_race: got %b want 0010", OVERRUN); end
    OVR_CLR = 1; tick(); OVR_CLR = 0;
    n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'd1) begin
      n_err++; $display("FAIL ovr_intr_held: got intr=%0b id=%0d want intr=1 id=1", INTR, INTR_ID); end
    INTR_ACK = 1; SRC_PULSE = 4'b0010; tick(); INTR_ACK = 0; SRC_PULSE = '0;
    n_cmp++; if (PENDING !== 4'b0010 || OVERRUN !== 4'b0) begin
      n_err++; $display("FAIL ack_cycle_pulse: got pend=%b ovr=%b want pend=0010 ovr=0000", PENDING, OVERRUN); end
  endtask

  task automatic test_mask();
    do_reset();
    SRC_PULSE = 4'b1000; tick(); SRC_PULSE = '0;
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (PENDING !== 4'b0 || INTR !== 1'b0 || OVERRUN !== 4'b0) begin
      n_err++; $display("FAIL masked_drop: got pend=%b intr=%0b ovr=%b want 0000/0/0000", PENDING, INTR, OVERRUN); end
    write_mask(4'b0100);
    MASK_WE = 1; MASK_IN = 4'b0000; SRC_PULSE = 4'b0100; tick(); MASK_WE = 0; SRC_PULSE = '0;
    tick();
    n_cmp++; if (PENDING !== 4'b0100 || MASK !== 4'b0000 || INTR !== 1'b0) begin
      n_err++; $display("FAIL pend_masked: got pend=%b mask=%b intr=%0b want 0100/0000/0", PENDING, MASK, INTR); end
    write_mask(4'b1000);
    for (int c = 0; c < 5; c++) tick();
    n_cmp++; if (INTR !== 1'b0) begin n_err++; $display("FAIL masked_no_intr: got %0b want 0", INTR); end
    write_mask(4'b1100); tick();
    n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'd2) begin
      n_err++; $display("FAIL unmask_grant: got intr=%0b id=%0d want intr=1 id=2", INTR, INTR_ID); end
    write_mask(4'b0000);
    n_cmp++; if (INTR !== 1'b1 || INTR_ID !== 2'd2) begin
      n_err++; $display("FAIL mask_in_assert: got intr=%0b id=%0d want intr=1 id=2", INTR, INTR_ID); end
  endtask

  task automatic test_reset_mid();
    do_reset(); write_mask(4'b1111);
    SRC_PULSE = 4'b0110; tick(); SRC_PULSE = '0; tick();
    n_cmp++; if (INTR !== 1'b1 || PENDING !== 4'b0110) begin
      n_err++; $display("FAIL pre_reset: got intr=%0b pend=%b want intr=1 pend=0110", INTR, PENDING); end
    RST = 1; tick(); RST = 0;
    n_cmp++; if (INTR !== 1'b0 || PENDING !== 4'b0 || MASK !== 4'b0 || INTR_ID !== 2'd0) begin
      n_err++; $display("FAIL mid_reset: got intr=%0b pend=%b mask=%b id=%0d want 0/0000/0000/0", INTR, PENDING, MASK, INTR_ID); end
    tick();
    n_cmp++; if (INTR !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got %0b want 0", INTR); end
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      RST       = ($urandom_range(0, 599) == 0);
      SRC_PULSE = 4'($urandom) & 4'($urandom);
      MASK_WE   = ($urandom_range(0, 15) == 0);
      MASK_IN   = 4'($urandom) | 4'($urandom);
      OVR_CLR   = ($urandom_range(0, 19) == 0);
      INTR_ACK  = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (INTR !== m_intr || INTR_ID !== 2'(m_id) || MASK !== m_mask || PENDING !== m_pend || OVERRUN !== m_ovr) begin
        n_err++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random c=%0d: got intr=%0b id=%0d mask=%b pend=%b ovr=%b want intr=%0b id=%0d mask=%b pend=%b ovr=%b",
                   c, INTR, INTR_ID, MASK, PENDING, OVERRUN, m_intr, m_id, m_mask, m_pend, m_ovr);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_latency_hold();
    test_ack_holdoff();
    test_rr_order();
    test_overrun();
    test_mask();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
